// File: rtl/dma_sync_fifo.sv
// Single-clock DMA buffer FIFO with registered read data, programmable almost-flags,
// occupancy count and synchronous flush. Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags.
module dma_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AE_LEVEL   = 2,
  parameter int AF_LEVEL   = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  localparam logic [LW-1:0]         DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]         AE_L    = LW'(AE_LEVEL);
  localparam logic [LW-1:0]         AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0]         LVL_ONE = LW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;

  logic rd_accept;
  logic wr_accept;
  logic do_rd;
  logic do_wr;

  // A write is allowed at full when a read frees a slot on the same edge.
  always_comb begin
    rd_accept = rd_en && !empty_q;
    wr_accept = wr_en && (!full_q || rd_accept);
    do_rd     = rd_accept && !clear;
    do_wr     = wr_accept && !clear;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem_q[rd_ptr_q];
      end
      unique case ({do_wr, do_rd})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    wr_ack_d   = do_wr;
    rd_valid_d = do_rd;

    // Status comes from the next level so it lines up with level after the edge.
    full_d   = (level_d == DEPTH_L);
    afull_d  = (level_d >= AF_L);
    empty_d  = (level_d == '0);
    aempty_d = (level_d <= AE_L);
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      empty_q    <= empty_d;
      aempty_q   <= aempty_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_en && full_q && !rd_accept) ovf_d = 1'b1;
      if (rd_en && empty_q)              udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign wr_ack       = wr_ack_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign level        = level_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;

endmodule

// File: tb/tb_dma_sync_fifo.sv
// Directed table-driven bench for dma_sync_fifo (default parameters).
module tb_dma_sync_fifo;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        almost_empty;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  dma_sync_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic        ack;
    logic        vld;
    logic [31:0] rd;
    logic [4:0]  lvl;
    logic        f;
    logic        af;
    logic        e;
    logic        ae;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic clr, input logic we, input logic [31:0] wd,
                              input logic re, input logic ack, input logic vld,
                              input logic [31:0] rd, input logic [4:0] lvl, input logic f,
                              input logic af, input logic e, input logic ae,
                              input logic ovf, input logic udf);
    vec_t v;
    v.clr = clr; v.we = we; v.wd = wd; v.re = re;
    v.ack = ack; v.vld = vld; v.rd = rd; v.lvl = lvl;
    v.f = f; v.af = af; v.e = e; v.ae = ae; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ack, input logic vld,
                         input logic [31:0] rd, input logic [4:0] lvl, input logic f,
                         input logic af, input logic e, input logic ae,
                         input logic ovf, input logic udf);
    chk({tag, ".wr_ack"},       32'(wr_ack),       32'(ack));
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(vld));
    chk({tag, ".rd_data"},      rd_data,           rd);
    chk({tag, ".level"},        32'(level),        32'(lvl));
    chk({tag, ".full"},         32'(full),         32'(f));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(af));
    chk({tag, ".empty"},        32'(empty),        32'(e));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".overflow"},     32'(overflow),     32'(ovf & ERR_EN));
    chk({tag, ".underflow"},    32'(underflow),    32'(udf & ERR_EN));
  endtask

  task automatic drive(input logic clr, input logic we, input logic [31:0] wd, input logic re);
    clear   = clr;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_d;
    logic [4:0]  lv;

    //          clr we  wd            re  ack vld rd            lvl f  af e  ae ovf udf
    vecs[0]  = mk(0, 1, 32'h0FCB01AA, 0,  1,  0,  32'h0,        1, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 1, 32'h0FCBCAFE, 0,  1,  0,  32'h0,        2, 0, 0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 32'h011CAFEF, 0,  1,  0,  32'h0,        3, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        1,  0,  1,  32'h0FCB01AA, 2, 0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        1,  0,  1,  32'h0FCBCAFE, 1, 0, 0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        1,  0,  1,  32'h011CAFEF, 0, 0, 0, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 32'h0,        1,  0,  0,  32'h011CAFEF, 0, 0, 0, 1, 1, 0, 1);
    vecs[7]  = mk(1, 0, 32'h0,        0,  0,  0,  32'h011CAFEF, 0, 0, 0, 1, 1, 0, 0);
    vecs[8]  = mk(0, 1, 32'h0000000A, 1,  1,  0,  32'h011CAFEF, 1, 0, 0, 0, 1, 0, 1);
    vecs[9]  = mk(0, 0, 32'h0,        1,  0,  1,  32'h0000000A, 0, 0, 0, 1, 1, 0, 1);
    vecs[10] = mk(1, 0, 32'h0,        0,  0,  0,  32'h0000000A, 0, 0, 0, 1, 1, 0, 0);

    reset = 1'b1;
    drive(0, 0, 32'h0, 0);
    #2;
    chk_all("reset", 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].clr, vecs[i].we, vecs[i].wd, vecs[i].re);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].vld, vecs[i].rd, vecs[i].lvl,
              vecs[i].f, vecs[i].af, vecs[i].e, vecs[i].ae, vecs[i].ovf, vecs[i].udf);
    end

    // Fill to full, watching almost_full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 32'h100 + i, 0);
      tick();
      lv = 5'(i + 1);
      chk_all($sformatf("fill%0d", i), 1, 0, 32'h0000000A, lv, lv == 5'd16, lv >= 5'd14,
              0, lv <= 5'd2, 0, 0);
    end

    // Simultaneous read+write while full keeps the FIFO full.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h200 + k, 1);
      tick();
      chk_all($sformatf("rw_full%0d", k), 1, 1, 32'h100 + k, 16, 1, 1, 0, 0, 0, 0);
    end

    drive(0, 1, 32'hDEAD, 0);
    tick();
    chk_all("overflow_wr", 0, 0, 32'h103, 16, 1, 1, 0, 0, 1, 0);

    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 32'h0, 1);
      tick();
      exp_d = (k < 12) ? 32'h104 + k : 32'h200 + (k - 12);
      lv    = 5'(15 - k);
      chk_all($sformatf("drain%0d", k), 0, 1, exp_d, lv, 0, lv >= 5'd14,
              lv == 5'd0, lv <= 5'd2, 1, 0);
    end

    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 32'h300 + k, 0);
      tick();
      lv = 5'(k + 1);
      chk_all($sformatf("load%0d", k), 1, 0, 32'h203, lv, 0, 0, 0, lv <= 5'd2, 1, 0);
    end

    drive(1, 1, 32'hBEEF, 1);
    tick();
    chk_all("clear_pri", 0, 0, 32'h203, 0, 0, 0, 1, 1, 0, 0);

    drive(0, 0, 32'h0, 1);
    tick();
    chk_all("rd_after_clear", 0, 0, 32'h203, 0, 0, 0, 1, 1, 0, 1);

    // Asynchronous reset between edges with 7 words stored.
    for (int k = 0; k < 7; k++) begin
      drive(0, 1, 32'h400 + k, 0);
      tick();
    end
    chk("pre_reset.level", 32'(level), 32'd7);
    drive(0, 0, 32'h0, 0);
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 0);
    #1;
    reset = 1'b0;

    drive(0, 1, 32'h77, 0);
    tick();
    chk_all("post_reset_wr", 1, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 32'h0, 1);
    tick();
    chk_all("post_reset_rd", 0, 1, 32'h77, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_sync_fifo.md
# dma_sync_fifo

Parametrised single-clock FIFO used inside the DMA path as the buffer between the ADMA engine and the SD data-line logic, replacing the fixed almost-flag FIFO where both sides run on one clock. It adds configurable width and depth, programmable almost-empty and almost-full thresholds, an occupancy count, a synchronous flush, registered read data with a valid strobe, and optional sticky overflow/underflow error flags for the ADMA error path.

## Interface
- DATA_WIDTH, 32, data word width in bits
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries
- AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL
- AF_LEVEL, 14, almost_full asserted when level >= AF_LEVEL (AE_LEVEL < AF_LEVEL <= DEPTH)

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush, one-cycle pulse
- wr_en  input  1  write request
- wr_data  input  DATA_WIDTH  write word
- wr_ack  output  1  write accepted this edge (registered pulse)
- full  output  1  level == DEPTH
- almost_full  output  1  level >= AF_LEVEL
- rd_en  input  1  read request
- rd_data  output  DATA_WIDTH  registered read word
- rd_valid  output  1  rd_data holds a newly popped word (one-cycle pulse)
- empty  output  1  level == 0
- almost_empty  output  1  level <= AE_LEVEL
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full (FIFO_ERR_FLAGS_EN only)
- underflow  output  1  sticky: read attempted while empty (FIFO_ERR_FLAGS_EN only)

## Operation
- Storage: DEPTH x DATA_WIDTH array; wr_ptr, rd_ptr of ADDR_WIDTH bits, wrap modulo DEPTH; level register of ADDR_WIDTH+1 bits.
- Write accept: wr_en && (!full || rd_accept). Stores wr_data at wr_ptr, increments wr_ptr.
- Read accept (rd_accept): rd_en && !empty. Loads mem[rd_ptr] into rd_data, increments rd_ptr.
- Simultaneous read and write: both accepted subject to the rules above; level unchanged. At full, both are accepted. At empty, only the write is accepted and underflow is set.
- level: +1 on write only, -1 on read only, unchanged on both or neither.
- All status outputs (full, empty, almost_*) are registered and derived from the next-state level, so they are consistent with level on the same edge.
- Rejected write: data is dropped, no wr_ack. Rejected read: rd_data holds, no rd_valid.
- clear: takes priority over wr_en/rd_en in that cycle; pointers and level go to 0; empty=1; almost_empty=1; wr_ack=0; rd_valid=0; rd_data holds; sticky flags are cleared. Memory contents are not cleared.
- reset (asynchronous): pointers=0, level=0, rd_data=0, wr_ack=0, rd_valid=0, full=0, almost_full=0, empty=1, almost_empty=1, overflow=0, underflow=0. Reset mid-transfer discards all contents.

## Timing
- Write-to-read latency: a word written at edge N is poppable at edge N+1 (empty deasserts after edge N); rd_data/rd_valid appear after the accepting edge.
- Read latency: 1 cycle; rd_valid is high for exactly the cycle following each accepted read.
- wr_ack is high for the cycle following each accepted write.
- Back-to-back: one write and one read per cycle is sustained indefinitely, with no bubbles.
- Flags never glitch, because they come from registers only.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow sets on wr_en && full && !rd_accept; underflow sets on rd_en && empty. Both are sticky until clear or reset.
- FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0; error logic is not built. Data-path behaviour is identical in both builds.

## Test plan
- Reset, then write 0x0FCB01AA, 0x0FCBCAFE, 0x011CAFEF on three consecutive edges -> level=3, empty=0, almost_empty=0 after third write; three reads return the same order with rd_valid pulses; level=0, empty=1.
- Fill with 16 writes (defaults) -> almost_full rises when level reaches 14, full at 16; 17th write -> wr_ack=0, level stays 16, overflow=1 (with FIFO_ERR_FLAGS_EN).
- At full, assert wr_en and rd_en together for 4 cycles -> level stays 16, 4 wr_acks, rd_data delivers the oldest 4 words in order, overflow not set.
- At empty, rd_en with wr_en=1, wr_data=0xA -> write accepted, no rd_valid, underflow=1, level=1; the next read returns 0xA.
- Load 5 words, then pulse clear with wr_en and rd_en high -> level=0, empty=1, no ack/valid that cycle, sticky flags cleared; a subsequent read is rejected.
- Assert reset asynchronously between edges at level 7 -> all outputs take their reset values immediately; after release, the first write/read pair returns the new word.
